// File: rtl/hysteresis_counter_table_pkg.sv
// rtl/hysteresis_counter_table_pkg.sv - shared constants and hysteresis helpers for the counter table
package hysteresis_counter_table_pkg;

    // Clear sweep FSM encoding
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SWEEP = 1'b1;

    // Highest value still on the "not taken" side of the midpoint
    function automatic int half_low(input int range);
        return range / 2 - 1;
    endfunction

    // Lowest value on the "taken" side of the midpoint
    function automatic int half_high(input int range);
        return range / 2;
    endfunction

    // Landing value when a decrement crosses the midpoint
    function automatic int jump_low(input int range, input int coercivity);
        return half_low(range) - coercivity;
    endfunction

    // Landing value when an increment crosses the midpoint
    function automatic int jump_high(input int range, input int coercivity);
        return half_high(range) + coercivity;
    endfunction

endpackage

// File: rtl/hysteresis_counter_step.sv
// rtl/hysteresis_counter_step.sv - combinational next-value rule for one hysteresis counter
module hysteresis_counter_step #(
    parameter int RANGE      = 4,
    parameter int RANGE_LOG2 = $clog2(RANGE),
    parameter int COERCIVITY = 1
) (
    input  logic [RANGE_LOG2-1:0] count,
    input  logic                  increment,
    input  logic                  decrement,
    output logic [RANGE_LOG2-1:0] next_count
);
    import hysteresis_counter_table_pkg::*;

    localparam logic [RANGE_LOG2-1:0] MAX_W       = RANGE_LOG2'(RANGE - 1);
    localparam logic [RANGE_LOG2-1:0] HALF_LOW_W  = RANGE_LOG2'(half_low(RANGE));
    localparam logic [RANGE_LOG2-1:0] HALF_HIGH_W = RANGE_LOG2'(half_high(RANGE));
    localparam logic [RANGE_LOG2-1:0] JUMP_LOW_W  = RANGE_LOG2'(jump_low(RANGE, COERCIVITY));
    localparam logic [RANGE_LOG2-1:0] JUMP_HIGH_W = RANGE_LOG2'(jump_high(RANGE, COERCIVITY));
    localparam logic [RANGE_LOG2-1:0] ONE_W       = RANGE_LOG2'(1);

    // Step one position, leaping across the midpoint; conflicting or saturating requests hold
    always_comb begin
        next_count = count;
        if (increment && !decrement && (count != MAX_W)) begin
            next_count = (count == HALF_LOW_W) ? JUMP_HIGH_W : count + ONE_W;
        end else if (decrement && !increment && (count != '0)) begin
            next_count = (count == HALF_HIGH_W) ? JUMP_LOW_W : count - ONE_W;
        end
    end

endmodule

// File: rtl/hysteresis_counter_table.sv
// rtl/hysteresis_counter_table.sv - indexed table of hysteresis counters with read, update and clear sweep
module hysteresis_counter_table #(
    parameter int RANGE       = 4,
    parameter int RANGE_LOG2  = $clog2(RANGE),
    parameter int RESET_VALUE = 0,
    parameter int COERCIVITY  = 1,
    parameter int DEPTH       = 16,
    parameter int DEPTH_LOG2  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  read_valid,
    input  logic [DEPTH_LOG2-1:0] read_index,
    output logic [RANGE_LOG2-1:0] read_count,
    output logic                  read_taken,
    input  logic                  update_valid,
    input  logic [DEPTH_LOG2-1:0] update_index,
    input  logic                  update_increment,
    input  logic                  update_decrement,
    input  logic                  clear,
    output logic                  busy
);
    import hysteresis_counter_table_pkg::*;

    localparam logic [RANGE_LOG2-1:0] RESET_W     = RANGE_LOG2'(RESET_VALUE);
    localparam logic [RANGE_LOG2-1:0] HALF_HIGH_W = RANGE_LOG2'(half_high(RANGE));
    localparam logic [DEPTH_LOG2:0]   DEPTH_W     = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX    = DEPTH_LOG2'(DEPTH - 1);

    logic                  state;
    logic [DEPTH_LOG2-1:0] sweep_index;
    logic [RANGE_LOG2-1:0] table_q [DEPTH];

    logic                  update_in_range;
    logic                  read_in_range;
    logic                  update_hit;
    logic [RANGE_LOG2-1:0] update_cur;
    logic [RANGE_LOG2-1:0] update_next;
    logic [RANGE_LOG2-1:0] read_value;

    assign update_in_range = ({1'b0, update_index} < DEPTH_W);
    assign read_in_range   = ({1'b0, read_index} < DEPTH_W);

    // An update lands only when idle, in range, and not pre-empted by a clear request
    assign update_hit = (state == ST_IDLE) && update_valid && !clear && update_in_range;

    // Current value of the entry being trained; out-of-range indexes never reach the array
    always_comb begin
        update_cur = RESET_W;
        if (update_in_range) begin
            update_cur = table_q[update_index];
        end
    end

    hysteresis_counter_step #(
        .RANGE      (RANGE),
        .RANGE_LOG2 (RANGE_LOG2),
        .COERCIVITY (COERCIVITY)
    ) u_step (
        .count      (update_cur),
        .increment  (update_increment),
        .decrement  (update_decrement),
        .next_count (update_next)
    );

    // Read mux with write-first bypass; sweeping or out-of-range reads see the reset value
    always_comb begin
        read_value = RESET_W;
        if ((state == ST_IDLE) && read_in_range) begin
            if (update_hit && (update_index == read_index)) begin
                read_value = update_next;
            end else begin
                read_value = table_q[read_index];
            end
        end
    end

    // Single write port shared by the clear sweep and the training update
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RESET_W;
            end
        end else if (state == ST_SWEEP) begin
            table_q[sweep_index] <= RESET_W;
        end else if (update_hit) begin
            table_q[update_index] <= update_next;
        end
    end

    // Registered read result, held between read requests
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_count <= RESET_W;
            read_taken <= (RESET_W >= HALF_HIGH_W);
        end else if (read_valid) begin
            read_count <= read_value;
            read_taken <= (read_value >= HALF_HIGH_W);
        end
    end

    // Clear sweep: one entry per cycle, ignoring further clears until the last entry is written
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            sweep_index <= '0;
        end else if (state == ST_IDLE) begin
            if (clear) begin
                state       <= ST_SWEEP;
                sweep_index <= '0;
            end
        end else begin
            if (sweep_index == LAST_IDX) begin
                state       <= ST_IDLE;
                sweep_index <= '0;
            end else begin
                sweep_index <= sweep_index + DEPTH_LOG2'(1);
            end
        end
    end

    assign busy = (state == ST_SWEEP);

endmodule
